// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl: circular-buffer capture into the sample memory, then oldest-first readback
// through a 2-entry output FIFO that absorbs the memory's one-cycle read latency.
module sample_capture_ctrl #(
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          trig,
  input  logic [AW-1:0] delay_count,
  input  logic          sample_valid,
  input  logic [8:0]    sample_data,
  input  logic          rd_start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  output logic          mem_dinp,
  input  logic [7:0]    mem_dout,
  input  logic          mem_doutp,
  output logic          out_valid,
  output logic [8:0]    out_data,
  input  logic          out_ready,
  output logic [2:0]    state,
  output logic [AW:0]   stored
);
  typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READ} state_t;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  state_t        st;
  logic [AW-1:0] wr_ptr, rd_addr, addr_q, post_cnt, dly;
  logic [AW:0]   rd_left;
  logic          wrap, inflight, wr, rd, pop, wp, rp;
  logic [1:0]    cnt;
  logic [8:0]    fifo [2];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // ARM outranks everything, so it also suppresses the same-cycle write or read
  assign dly       = (delay_count > LAST) ? LAST : delay_count;
  assign wr        = ~arm & sample_valid & (st == ARMED || st == POST);
  assign pop       = out_valid & out_ready;
  assign rd        = ~arm & (st == READ) & (rd_left != '0) &
                     (({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  assign mem_en    = wr | rd;
  assign mem_we    = wr;
  assign mem_addr  = wr ? wr_ptr : rd ? rd_addr : addr_q;
  assign mem_din   = wr ? sample_data[7:0] : '0;
  assign mem_dinp  = wr & sample_data[8];
  assign out_valid = cnt != '0;
  assign out_data  = fifo[rp];
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      rd_addr  <= '0;
      addr_q   <= '0;
      post_cnt <= '0;
      rd_left  <= '0;
      stored   <= '0;
      wrap     <= 1'b0;
      inflight <= 1'b0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= '0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      addr_q <= mem_addr;
      if (arm) begin
        st       <= ARMED;
        wr_ptr   <= '0;
        wrap     <= 1'b0;
        stored   <= '0;
        rd_left  <= '0;
        inflight <= 1'b0;
        wp       <= 1'b0;
        rp       <= 1'b0;
        cnt      <= '0;
      end else begin
        if (wr) begin
          wr_ptr <= nxt(wr_ptr);
          if (wr_ptr == LAST) wrap <= 1'b1;
          if (stored != FULL) stored <= stored + 1'b1;
        end
        if (rd) begin
          rd_addr <= nxt(rd_addr);
          rd_left <= rd_left - 1'b1;
        end
        // inflight marks the cycle in which the memory presents the word read last cycle
        inflight <= rd;
        if (inflight) begin
          fifo[wp] <= {mem_doutp, mem_dout};
          wp       <= ~wp;
        end
        if (pop) rp <= ~rp;
        cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        case (st)
          IDLE: ;
          ARMED: if (sample_valid && trig) begin
            post_cnt <= dly;
            st       <= (dly == '0) ? DONE : POST;
          end
          POST: if (sample_valid) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) st <= DONE;
          end
          DONE: if (rd_start) begin
            rd_addr <= wrap ? wr_ptr : '0;
            rd_left <= stored;
            st      <= (stored == '0) ? DONE : READ;
          end
          READ: if (pop && cnt == 2'd1 && !inflight && rd_left == '0) st <= DONE;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_capture_ctrl.sv
// tb_sample_capture_ctrl: directed capture/readback scenarios against a behavioural 6K x 9 memory.
module tb_sample_capture_ctrl;
  localparam int DEPTH = 6144;
  localparam int AW    = 13;
  logic          clk = 0, rst_n = 1, arm = 0, trig = 0, sample_valid = 0, rd_start = 0, out_ready = 0;
  logic [AW-1:0] delay_count = '0;
  logic [8:0]    sample_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we, mem_dinp;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = '0;
  logic          mem_doutp = 1'b0;
  logic          out_valid;
  logic [8:0]    out_data;
  logic [2:0]    state;
  logic [AW:0]   stored;
  logic [8:0]    mem [DEPTH];
  int checks = 0, errors = 0, addr_bad = 0, we_in_read = 0;

  typedef struct {
    int trig_at;
    int dly;
    int total;
    int s;
    int pre;
    int first;
    int last;
  } cap_t;
  cap_t tbl [6];

  sample_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .delay_count(delay_count),
    .sample_valid(sample_valid), .sample_data(sample_data), .rd_start(rd_start),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dinp(mem_dinp), .mem_dout(mem_dout), .mem_doutp(mem_doutp),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .state(state), .stored(stored)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en && int'(mem_addr) < DEPTH) begin
      if (mem_we) mem[mem_addr] <= {mem_dinp, mem_din};
      else {mem_doutp, mem_dout} <= mem[mem_addr];
    end

  always @(negedge clk) begin
    if (mem_en && int'(mem_addr) >= DEPTH) addr_bad++;
    if (state == 3'd4 && mem_we) we_in_read++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic capture(input cap_t c);
    for (int i = 0; i < c.total; i++) begin
      if (i == c.total - 1) begin
        @(negedge clk);
        chk("pre_done_state", state, c.pre);
      end
      sample_valid = 1;
      sample_data  = 9'(i % 512);
      trig         = i >= c.trig_at;
      delay_count  = AW'(c.dly);
      tick();
    end
    sample_valid = 0;
    trig = 0;
    @(negedge clk);
    chk("done_state", state, 3);
    chk("stored", stored, c.s);
    chk("addr_hold", mem_addr, (c.total - 1) % DEPTH);
    sample_valid = 1;
    trig = 1;
    sample_data = 9'h155;
    repeat (3) tick();
    @(negedge clk);
    chk("trig_in_done_state", state, 3);
    chk("trig_in_done_we", mem_we, 0);
    chk("trig_in_done_stored", stored, c.s);
    sample_valid = 0;
    trig = 0;
  endtask

  task automatic readback(input int s, input int first_val, input int last_val, input int pct);
    int got, bad, first, lastpop, lastval;
    got = 0; bad = 0; first = -1; lastpop = -1; lastval = -1;
    rd_start = 1;
    tick();
    rd_start = 0;
    for (int c = 1; c < s * 8 + 20 && got < s; c++) begin
      out_ready = $urandom_range(99) < pct;
      @(negedge clk);
      if (c == 1) chk("first_read_issue", {mem_en, mem_we}, 2'b10);
      if (out_valid && first < 0) first = c;
      if (out_valid && out_ready) begin
        if (out_data !== 9'((first_val + got) % 512)) bad++;
        lastval = int'(out_data);
        got++;
        lastpop = c;
      end
      tick();
    end
    out_ready = 0;
    @(negedge clk);
    chk("rd_exit_state", state, 3);
    chk("rd_exit_valid", out_valid, 0);
    chk("rd_latency", first, 3);
    chk("rd_words", got, s);
    chk("rd_order_bad", bad, 0);
    chk("rd_last_word", lastval, last_val);
    if (pct == 100) chk("rd_throughput", lastpop, s + 2);
  endtask

  initial begin
    int pops;
    tbl[0] = '{trig_at: 3,    dly: 6,      total: 10,   s: 10,   pre: 2, first: 0,   last: 9};
    tbl[1] = '{trig_at: 6999, dly: 0,      total: 7000, s: 6144, pre: 1, first: 344, last: 343};
    tbl[2] = '{trig_at: 0,    dly: 'h1FFF, total: 6144, s: 6144, pre: 2, first: 0,   last: 511};
    tbl[3] = '{trig_at: 0,    dly: 0,      total: 1,    s: 1,    pre: 1, first: 0,   last: 0};
    tbl[4] = '{trig_at: 5,    dly: 1,      total: 7,    s: 7,    pre: 2, first: 0,   last: 6};
    tbl[5] = '{trig_at: 6200, dly: 10,     total: 6211, s: 6144, pre: 2, first: 67,  last: 66};
    #2 rst_n = 0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_stored", stored, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pins", {mem_en, mem_we, mem_dinp}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick();
    // stimulus that must be ignored while idle
    trig = 1; sample_valid = 1; rd_start = 1;
    @(negedge clk);
    chk("idle_no_write", mem_en, 0);
    tick();
    @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_stored", stored, 0);
    trig = 0; sample_valid = 0; rd_start = 0;
    for (int k = 0; k < 6; k++) begin
      do_arm();
      capture(tbl[k]);
      readback(tbl[k].s, tbl[k].first, tbl[k].last, 100);
      if (tbl[k].s <= 16) readback(tbl[k].s, tbl[k].first, tbl[k].last, 40);
    end
    // abort a readback after three pops
    do_arm();
    capture(tbl[0]);
    rd_start = 1;
    tick();
    rd_start = 0;
    out_ready = 1;
    pops = 0;
    for (int c = 0; c < 20 && pops < 3; c++) begin
      @(negedge clk);
      if (out_valid) pops++;
      tick();
    end
    chk("abort_pops", pops, 3);
    arm = 1;
    @(negedge clk);
    chk("abort_no_read", mem_en, 0);
    tick();
    arm = 0;
    out_ready = 0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_state", state, 1);
    chk("abort_stored", stored, 0);
    rd_start = 1;
    tick();
    rd_start = 0;
    @(negedge clk);
    chk("armed_rdstart_state", state, 1);
    chk("armed_rdstart_valid", out_valid, 0);
    // asynchronous reset in the middle of POST
    sample_valid = 1; trig = 1; delay_count = AW'(20); sample_data = 9'h005;
    tick();
    trig = 0;
    repeat (3) tick();
    sample_data = 9'h1FF;
    @(negedge clk);
    chk("post_state", state, 2);
    chk("post_stored", stored, 4);
    #1 rst_n = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_stored", stored, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_pins", {mem_en, mem_we, mem_dinp}, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_din", mem_din, 0);
    sample_valid = 0;
    @(negedge clk) rst_n = 1;
    tick();
    @(negedge clk);
    chk("after_rst_state", state, 0);
    chk("addr_range", addr_bad, 0);
    chk("we_in_read", we_in_read, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_capture_ctrl.md
# sample_capture_ctrl

Capture and readback controller for the 6K x 9-bit sample memory in the logic-analyzer core. During capture it writes incoming 9-bit samples into the memory as a circular buffer and stops a programmable number of samples after a trigger. It then streams the stored samples out, oldest first, on a valid/ready interface, absorbing the memory's one-cycle read latency. It is the only master of the memory's ADDR/WE/EN/DIN pins.

## Interface
- DEPTH, 6144, number of memory words; legal addresses are 0..DEPTH-1.
- AW, 13, address width.
- CLK  in  1  clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ARM  in  1  one-cycle pulse that starts or restarts a capture.
- TRIG  in  1  trigger qualifier; only sampled together with SAMPLE_VALID.
- DELAY_COUNT  in  AW  number of post-trigger samples; values above DEPTH-1 clamp to DEPTH-1.
- SAMPLE_VALID  in  1  a sample is present this cycle.
- SAMPLE_DATA  in  9  sample; bit 8 is the parity/extra bit.
- RD_START  in  1  one-cycle pulse that starts readback; honoured only in DONE.
- MEM_ADDR  out  AW  memory address.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_DIN  out  8  write data.
- MEM_DINP  out  1  write parity bit.
- MEM_DOUT  in  8  read data, valid one cycle after an enabled read.
- MEM_DOUTP  in  1  read parity bit.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_DATA  out  9  readback sample as {MEM_DOUTP, MEM_DOUT}.
- OUT_READY  in  1  consumer accepts the word.
- STATE  out  3  encoded state: IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
- STORED  out  AW+1  number of valid samples in the buffer, 0..DEPTH.

## Operation
- **States.**
  - IDLE: waits for ARM.
  - ARMED: ARM moves to this state; write pointer, wrap flag and STORED clear.
  - ARMED, on SAMPLE_VALID: writes the sample. If TRIG is also high, loads the post counter with the clamped DELAY_COUNT and moves to POST; if that value is 0, moves directly to DONE.
  - POST, on SAMPLE_VALID: writes the sample and decrements the counter. The write that takes the counter from 1 to 0 moves to DONE.
  - DONE, on RD_START: moves to READ.
  - READ: exits to DONE once all STORED words have been accepted.
- **TRIG scope.** TRIG is ignored outside ARMED.
- **ARM priority.** ARM in any state aborts the current activity, flushes the output buffer and enters ARMED. ARM has priority over every other event in the same cycle.
- **Write path (combinational, capture states only).**
  - MEM_EN = MEM_WE = SAMPLE_VALID.
  - MEM_ADDR = wr_ptr.
  - MEM_DIN = SAMPLE_DATA[7:0], MEM_DINP = SAMPLE_DATA[8].
- **Pointer and count.**
  - wr_ptr increments by 1 per write and wraps DEPTH-1 -> 0. It never produces an address of DEPTH or above.
  - Wrapping sets the wrap flag.
  - STORED saturates at DEPTH.
- **Readback.**
  - Start address is wr_ptr if the wrap flag is set, otherwise 0.
  - The read address increments with the same wrap rule as wr_ptr.
  - Exactly STORED reads are issued.
  - MEM_WE is 0 throughout READ.
- **Output buffer.**
  - The output uses a 2-entry FIFO.
  - A read is issued (MEM_EN=1) in a cycle only if (FIFO entries + reads in flight - pop this cycle) < 2 and reads remain.
  - The returned word enters the FIFO in the next cycle.
  - OUT_VALID reflects a non-empty FIFO; a pop occurs when OUT_VALID and OUT_READY are both high.
- **Idle memory pins.** Outside active writes or reads: MEM_EN=0, MEM_WE=0, and MEM_ADDR holds its last value.

## Timing
- **Reset values.** STATE=IDLE, STORED=0, OUT_VALID=0, OUT_DATA=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_DIN=0, MEM_DINP=0. All internal pointers and counters reset to 0. Reset mid-capture or mid-readback discards everything.
- **Write timing.** A sample is written in the same cycle it is presented. STATE and STORED update on the following edge.
- **Read latency.** With RD_START at cycle t:
  - first read is issued at t+1;
  - first OUT_VALID is at t+3.
- **Throughput.** With OUT_READY held high, one word per cycle until STORED words are delivered.
- **Backpressure.** With OUT_READY low, OUT_DATA and OUT_VALID hold and no word is lost or duplicated.
- **Exit from READ.** READ -> DONE on the edge after the last pop. A second RD_START replays the same data.
- **Empty buffer.** If STORED=0 when RD_START arrives, go directly back to DONE with no reads and no OUT_VALID.

## Test plan
- **Short capture, no wrap.** ARM; 10 samples 0x000..0x009 with TRIG on the 4th, DELAY_COUNT=6 -> DONE after the 10th write, STORED=10, readback 0x000..0x009 in order, first OUT_VALID 3 cycles after RD_START.
- **Wrap-around.** ARM; 7000 samples (data = index mod 512), TRIG on sample 6999, DELAY_COUNT=0 -> STORED=6144, first output is sample 856, last is sample 6999, MEM_ADDR never exceeds 0x17FF.
- **Backpressure.** During readback of 10 words, toggle OUT_READY randomly (40% high) -> exactly 10 words, in order, with no duplicates.
- **Abort and reset.** ARM during READ after 3 pops -> OUT_VALID drops the next cycle, STATE=ARMED, STORED=0. Separately, assert RST_N low mid-POST -> all outputs take their reset values asynchronously.
- **Clamp and ignore rules.** DELAY_COUNT=0x1FFF -> POST lasts 6143 samples. TRIG asserted in IDLE or DONE -> no state change. RD_START in ARMED -> ignored.
